// File: rtl/mult_acc_pkg.sv
// Shared helpers for the signed multiply-accumulator: saturating wide add and parameter checks.
// Latency: purely combinational functions, no state.
// Backpressure: not applicable.
package mult_acc_pkg;

   // Working width for the saturating add; every legal ACC_WIDTH is strictly narrower.
   localparam int SAT_W = 64;

   typedef logic signed [SAT_W-1:0] wide_t;

   // Largest positive value representable in an acc_w-bit signed accumulator.
   function automatic logic signed [SAT_W:0] acc_max(input int acc_w);
      logic signed [SAT_W:0] one;
      one = {{SAT_W{1'b0}}, 1'b1};
      return (one <<< (acc_w - 1)) - one;
   endfunction

   // Exact sum of two sign-extended operands, one bit wider so it cannot wrap.
   function automatic logic signed [SAT_W:0] ext_add(input wide_t x, input wide_t y);
      return {x[SAT_W-1], x} + {y[SAT_W-1], y};
   endfunction

   // base + addend, clamped to the acc_w-bit signed range.
   function automatic wide_t sat_add(input wide_t base, input wide_t addend, input int acc_w);
      logic signed [SAT_W:0] s;
      logic signed [SAT_W:0] hi;
      logic signed [SAT_W:0] lo;
      s  = ext_add(base, addend);
      hi = acc_max(acc_w);
      lo = -hi - {{SAT_W{1'b0}}, 1'b1};
      if (s > hi) begin
         return hi[SAT_W-1:0];
      end else if (s < lo) begin
         return lo[SAT_W-1:0];
      end
      return s[SAT_W-1:0];
   endfunction

   // High when base + addend falls outside the acc_w-bit signed range.
   function automatic logic sat_hit(input wide_t base, input wide_t addend, input int acc_w);
      logic signed [SAT_W:0] s;
      logic signed [SAT_W:0] hi;
      logic signed [SAT_W:0] lo;
      s  = ext_add(base, addend);
      hi = acc_max(acc_w);
      lo = -hi - {{SAT_W{1'b0}}, 1'b1};
      return (s > hi) || (s < lo);
   endfunction

   // Legal parameter combination for mult_acc_signed.
   function automatic bit cfg_ok(input int wa, input int wb, input int acc_w,
                                 input int out_w, input int shift, input int delay);
      return (acc_w >= wa + wb) && (acc_w < SAT_W) && (out_w >= 2) && (out_w <= acc_w) &&
             (shift >= 0) && (shift <= acc_w - out_w) && (delay >= 2);
   endfunction

endpackage

// File: rtl/round_sat.sv
// round_sat: round-half-up arithmetic right shift of a signed value, then clamp to OUT_WIDTH.
// Latency: combinational.
// Backpressure: not applicable.
module round_sat #(
   parameter int IN_WIDTH  = 40,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT     = 15
)(
   input  logic signed [IN_WIDTH-1:0]  din_i,
   output logic signed [OUT_WIDTH-1:0] dout_o,
   output logic                        clamp_o
);

   // One guard bit so the rounding increment can never wrap.
   localparam int XW = IN_WIDTH + 1;
   localparam logic signed [XW-1:0] MAX_V = {{(XW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0] MIN_V = {{(XW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic signed [XW-1:0] ext;
   logic signed [XW-1:0] shifted;

   assign ext = XW'(din_i);

   if (SHIFT > 0) begin : g_round
      localparam logic signed [XW-1:0] HALF = XW'(1) <<< (SHIFT - 1);
      assign shifted = (ext + HALF) >>> SHIFT;
   end else begin : g_pass
      assign shifted = ext;
   end

   // Clamp the shifted value into the output range and flag when clamping bites.
   always_comb begin
      dout_o  = shifted[OUT_WIDTH-1:0];
      clamp_o = 1'b0;
      if (shifted > MAX_V) begin
         dout_o  = MAX_V[OUT_WIDTH-1:0];
         clamp_o = 1'b1;
      end else if (shifted < MIN_V) begin
         dout_o  = MIN_V[OUT_WIDTH-1:0];
         clamp_o = 1'b1;
      end
   end

endmodule

// File: rtl/mult_acc_signed.sv
// mult_acc_signed: signed MAC over first/last-delimited frames, one rounded/saturated sum per frame.
// Latency: last beat at cycle t gives out_valid at t+OUTPUT_DELAY+2; one frame dump per cycle.
// Backpressure: none; a beat is accepted every cycle and in_valid=0 is a bubble.
module mult_acc_signed
   import mult_acc_pkg::*;
#(
   parameter int DATA_WIDTHA  = 16,
   parameter int DATA_WIDTHB  = 16,
   parameter int ACC_WIDTH    = 40,
   parameter int OUT_WIDTH    = 16,
   parameter int SHIFT        = 15,
   parameter int OUTPUT_DELAY = 2
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic                          first,
   input  logic                          last,
   input  logic signed [DATA_WIDTHA-1:0] a,
   input  logic signed [DATA_WIDTHB-1:0] b,
   output logic                          out_valid,
   output logic signed [OUT_WIDTH-1:0]   result,
   output logic                          sat
);

   localparam int  PW     = DATA_WIDTHA + DATA_WIDTHB;
   localparam int  PD     = OUTPUT_DELAY - 1;
   localparam bit  CFG_OK = cfg_ok(DATA_WIDTHA, DATA_WIDTHB, ACC_WIDTH, OUT_WIDTH, SHIFT, OUTPUT_DELAY);

   if (!CFG_OK) begin : g_cfg_err
      $error("mult_acc_signed: illegal parameter combination");
   end

   // ---------------- product stage ----------------
   logic signed [DATA_WIDTHA-1:0] a_q;
   logic signed [DATA_WIDTHB-1:0] b_q;
   logic [OUTPUT_DELAY-1:0]       vld_q;
   logic [OUTPUT_DELAY-1:0]       first_q;
   logic [OUTPUT_DELAY-1:0]       last_q;
   logic signed [PW-1:0]          prod_q [PD];

   // Register operands, multiply, and delay product and sideband by the same number of stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         vld_q   <= '0;
         first_q <= '0;
         last_q  <= '0;
         for (int k = 0; k < PD; k++) prod_q[k] <= '0;
      end else begin
         a_q       <= a;
         b_q       <= b;
         vld_q     <= {vld_q[OUTPUT_DELAY-2:0], in_valid};
         first_q   <= {first_q[OUTPUT_DELAY-2:0], in_valid & first};
         last_q    <= {last_q[OUTPUT_DELAY-2:0], in_valid & last};
         prod_q[0] <= PW'(a_q) * PW'(b_q);
         for (int k = 1; k < PD; k++) prod_q[k] <= prod_q[k-1];
      end
   end

   logic              p_vld;
   logic              p_first;
   logic              p_last;
   logic signed [PW-1:0] p_prod;

   assign p_vld   = vld_q[OUTPUT_DELAY-1];
   assign p_first = first_q[OUTPUT_DELAY-1];
   assign p_last  = last_q[OUTPUT_DELAY-1];
   assign p_prod  = prod_q[PD-1];

   // ---------------- accumulate stage ----------------
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        frame_sat_q, frame_sat_d;
   logic signed [ACC_WIDTH-1:0] dump_q, dump_d;
   logic                        dump_sat_q, dump_sat_d;
   logic                        dump_vld_q, dump_vld_d;
   logic signed [ACC_WIDTH-1:0] base;
   logic signed [ACC_WIDTH-1:0] acc_sum;
   logic                        beat_sat;

   // Next accumulator / dump state: first restarts from zero, last hands the sum to the dump register.
   always_comb begin
      base        = p_first ? '0 : acc_q;
      acc_sum     = ACC_WIDTH'(sat_add(SAT_W'(base), SAT_W'(p_prod), ACC_WIDTH));
      beat_sat    = (p_first ? 1'b0 : frame_sat_q) | sat_hit(SAT_W'(base), SAT_W'(p_prod), ACC_WIDTH);
      acc_d       = acc_q;
      frame_sat_d = frame_sat_q;
      dump_d      = dump_q;
      dump_sat_d  = dump_sat_q;
      dump_vld_d  = 1'b0;
      if (p_vld) begin
         if (p_last) begin
            acc_d       = '0;
            frame_sat_d = 1'b0;
            dump_d      = acc_sum;
            dump_sat_d  = beat_sat;
            dump_vld_d  = 1'b1;
         end else begin
            acc_d       = acc_sum;
            frame_sat_d = beat_sat;
         end
      end
   end

   // Accumulator and dump registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q       <= '0;
         frame_sat_q <= 1'b0;
         dump_q      <= '0;
         dump_sat_q  <= 1'b0;
         dump_vld_q  <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         frame_sat_q <= frame_sat_d;
         dump_q      <= dump_d;
         dump_sat_q  <= dump_sat_d;
         dump_vld_q  <= dump_vld_d;
      end
   end

   // ---------------- output stage ----------------
   logic signed [OUT_WIDTH-1:0] rs_val;
   logic                        rs_clamp;
   logic                        out_valid_q;
   logic signed [OUT_WIDTH-1:0] result_q;
   logic                        sat_q;

   round_sat #(
      .IN_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT)
   ) u_round_sat (
      .din_i   (dump_q),
      .dout_o  (rs_val),
      .clamp_o (rs_clamp)
   );

   // Register the rounded result; result and sat hold between pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         sat_q       <= 1'b0;
      end else begin
         out_valid_q <= dump_vld_q;
         if (dump_vld_q) begin
            result_q <= rs_val;
            sat_q    <= dump_sat_q | rs_clamp;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_mult_acc_signed.sv
// Self-checking bench for mult_acc_signed: default config plus an ACC_WIDTH=32/SHIFT=16 instance.
// Latency: expects each frame result four cycles after its last beat.
// Backpressure: none; stimulus is applied every cycle.
module tb_mult_acc_signed;

   logic clk = 1'b0;
   logic reset, in_valid, first, last;
   logic signed [15:0] a, b;
   logic out_valid, sat, out_valid32, sat32;
   logic signed [15:0] result, result32;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct packed {
      logic signed [15:0] r;
      logic               s;
      logic [31:0]        c;
   } ev_t;

   ev_t obs[$], obs32[$], exp_q[$], exp32[$];
   longint m_acc = 0, m_acc32 = 0;
   bit     m_fs = 0, m_fs32 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mult_acc_signed dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .first(first), .last(last),
      .a(a), .b(b), .out_valid(out_valid), .result(result), .sat(sat)
   );

   mult_acc_signed #(.ACC_WIDTH(32), .SHIFT(16)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .first(first), .last(last),
      .a(a), .b(b), .out_valid(out_valid32), .result(result32), .sat(sat32)
   );

   // Record every output pulse with the cycle it appeared in.
   always @(negedge clk) begin
      if (out_valid === 1'b1)   obs.push_back('{result, sat, 32'(cyc)});
      if (out_valid32 === 1'b1) obs32.push_back('{result32, sat32, 32'(cyc)});
   end

   // Frame-level reference: exact integer sum, clamp to accumulator range, round, clamp to 16 bits.
   task automatic model_beat(input bit f, input bit l, input longint p, input int accw, input int sh,
                             inout longint acc, inout bit fs, output bit emit, output ev_t ev);
      longint hi, lo, s, r;
      hi = (64'sd1 <<< (accw - 1)) - 1;
      lo = -hi - 1;
      if (f) begin acc = 0; fs = 0; end
      s = acc + p;
      if (s > hi) begin s = hi; fs = 1; end
      else if (s < lo) begin s = lo; fs = 1; end
      emit = 0;
      ev = '0;
      if (l) begin
         if (sh > 0) r = (s + (64'sd1 <<< (sh - 1))) >>> sh;
         else r = s;
         ev.s = fs;
         if (r > 32767) begin r = 32767; ev.s = 1; end
         else if (r < -32768) begin r = -32768; ev.s = 1; end
         ev.r = 16'(r);
         ev.c = 32'(cyc + 4);
         emit = 1;
         acc = 0;
         fs = 0;
      end else begin
         acc = s;
      end
   endtask

   task automatic beat(input bit v, input bit f, input bit l, input logic signed [15:0] av,
                       input logic signed [15:0] bv);
      bit e;
      ev_t ev;
      longint p;
      in_valid = v; first = f; last = l; a = av; b = bv;
      if (v) begin
         p = longint'(av) * longint'(bv);
         model_beat(f, l, p, 40, 15, m_acc, m_fs, e, ev);
         if (e) exp_q.push_back(ev);
         model_beat(f, l, p, 32, 16, m_acc32, m_fs32, e, ev);
         if (e) exp32.push_back(ev);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(0, 0, 0, 16'sh0000, 16'sh0000);
   endtask

   task automatic start();
      obs.delete(); obs32.delete(); exp_q.delete(); exp32.delete();
   endtask

   task automatic test_reset();
      checks++;
      if (out_valid !== 1'b0 || result !== 16'sh0000 || sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got v=%b r=%h s=%b, want 0 0 0", out_valid, result, sat);
      end
      checks++;
      if (out_valid32 !== 1'b0 || result32 !== 16'sh0000 || sat32 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state32: got v=%b r=%h s=%b, want 0 0 0", out_valid32, result32, sat32);
      end
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_single();
      int t0;
      start();
      t0 = cyc;
      beat(1, 1, 1, 16'sh4000, 16'sh4000);
      idle(6);
      checks++;
      if (obs.size() !== 1) begin
         errors++; $display("FAIL single_count: got %0d, want 1", obs.size());
      end else begin
         checks++;
         if (obs[0].r !== 16'sh2000 || obs[0].s !== 1'b0 || obs[0].c !== 32'(t0 + 4)) begin
            errors++;
            $display("FAIL single_value: got r=%h s=%b cyc=%0d, want r=2000 s=0 cyc=%0d",
                     obs[0].r, obs[0].s, obs[0].c, t0 + 4);
         end
      end
   endtask

   task automatic test_rounding();
      logic signed [15:0] want [3];
      want[0] = 16'sh0001; want[1] = 16'sh0000; want[2] = 16'sh0000;
      start();
      beat(1, 1, 1, 16'sh0001, 16'sh4000);
      beat(1, 1, 1, 16'sh0001, 16'sh3FFF);
      beat(1, 1, 1, 16'shFFFF, 16'sh4000);
      idle(6);
      checks++;
      if (obs.size() !== 3) begin
         errors++; $display("FAIL round_count: got %0d, want 3", obs.size());
      end
      for (int i = 0; i < 3; i++) begin
         if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i] || obs[i].r !== want[i]) begin
               errors++;
               $display("FAIL round_%0d: got r=%0d s=%b cyc=%0d, want r=%0d s=%b cyc=%0d",
                        i, obs[i].r, obs[i].s, obs[i].c, want[i], exp_q[i].s, exp_q[i].c);
            end
         end
      end
   endtask

   task automatic test_saturation();
      start();
      beat(1, 1, 0, 16'sh7FFF, 16'sh7FFF);
      beat(1, 0, 0, 16'sh7FFF, 16'sh7FFF);
      beat(1, 0, 1, 16'sh7FFF, 16'sh7FFF);
      beat(1, 1, 1, 16'sh4000, 16'sh4000);
      idle(6);
      checks++;
      if (obs.size() !== 2) begin
         errors++; $display("FAIL sat_count: got %0d, want 2", obs.size());
      end else begin
         checks++;
         if (obs[0].r !== 16'sh7FFF || obs[0].s !== 1'b1 || obs[0] !== exp_q[0]) begin
            errors++; $display("FAIL sat_clamp: got r=%h s=%b, want r=7fff s=1", obs[0].r, obs[0].s);
         end
         checks++;
         if (obs[1].r !== 16'sh2000 || obs[1].s !== 1'b0 || obs[1] !== exp_q[1]) begin
            errors++; $display("FAIL sat_cleared: got r=%h s=%b, want r=2000 s=0", obs[1].r, obs[1].s);
         end
      end
   endtask

   task automatic test_bubbles_abandon();
      start();
      beat(1, 1, 0, 16'sh4000, 16'sh4000);
      beat(0, 1, 1, 16'sh7FFF, 16'sh7FFF);
      beat(1, 0, 1, 16'sh4000, 16'sh4000);
      beat(1, 1, 0, 16'sh7000, 16'sh7000);
      beat(1, 1, 0, 16'sh0100, 16'sh0100);
      beat(0, 0, 0, 16'sh1234, 16'sh5678);
      beat(1, 0, 1, 16'sh0100, 16'sh0100);
      idle(6);
      checks++;
      if (obs.size() !== 2) begin
         errors++; $display("FAIL bub_count: got %0d, want 2", obs.size());
      end else begin
         checks++;
         if (obs[0].r !== 16'sh4000 || obs[0] !== exp_q[0]) begin
            errors++; $display("FAIL bub_bubble: got r=%h cyc=%0d, want r=4000 cyc=%0d", obs[0].r, obs[0].c, exp_q[0].c);
         end
         checks++;
         if (obs[1].r !== 16'sh0004 || obs[1].s !== 1'b0 || obs[1] !== exp_q[1]) begin
            errors++; $display("FAIL bub_abandon: got r=%h s=%b, want r=0004 s=0", obs[1].r, obs[1].s);
         end
      end
   endtask

   task automatic test_acc32();
      start();
      beat(1, 1, 0, 16'sh8000, 16'sh8000);
      beat(1, 0, 0, 16'sh8000, 16'sh8000);
      beat(1, 0, 1, 16'sh8000, 16'sh8000);
      idle(6);
      checks++;
      if (obs32.size() !== 1) begin
         errors++; $display("FAIL acc32_count: got %0d, want 1", obs32.size());
      end else begin
         checks++;
         if (obs32[0].r !== 16'sh7FFF || obs32[0].s !== 1'b1 || obs32[0] !== exp32[0]) begin
            errors++; $display("FAIL acc32_value: got r=%h s=%b, want r=7fff s=1", obs32[0].r, obs32[0].s);
         end
      end
      checks++;
      if (obs.size() !== 1 || obs[0] !== exp_q[0]) begin
         errors++; $display("FAIL acc32_default_cfg: got %0d pulses, want 1 matching model", obs.size());
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      start();
      t0 = cyc;
      for (int i = 0; i < 20; i++) beat(1, 1, 1, 16'($urandom), 16'($urandom));
      idle(6);
      checks++;
      if (obs.size() !== 20) begin
         errors++; $display("FAIL b2b_count: got %0d, want 20", obs.size());
      end
      for (int i = 0; i < 20; i++) begin
         if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i] || obs[i].c !== 32'(t0 + 4 + i)) begin
               errors++;
               $display("FAIL b2b_%0d: got r=%0d s=%b cyc=%0d, want r=%0d s=%b cyc=%0d",
                        i, obs[i].r, obs[i].s, obs[i].c, exp_q[i].r, exp_q[i].s, t0 + 4 + i);
            end
         end
      end
   endtask

   task automatic test_random_frames();
      logic signed [15:0] ra, rb;
      start();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            ra = 16'($urandom); rb = 16'($urandom);
         end else begin
            ra = 16'($urandom_range(0, 511)) - 16'sd256; rb = 16'($urandom_range(0, 511)) - 16'sd256;
         end
         beat($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, ra, rb);
      end
      idle(6);
      checks++;
      if (obs.size() !== exp_q.size()) begin
         errors++; $display("FAIL rand_count: got %0d, want %0d", obs.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL rand_%0d: got r=%0d s=%b cyc=%0d, want r=%0d s=%b cyc=%0d",
                        i, obs[i].r, obs[i].s, obs[i].c, exp_q[i].r, exp_q[i].s, exp_q[i].c);
            end
         end
      end
      checks++;
      if (obs32.size() !== exp32.size()) begin
         errors++; $display("FAIL rand32_count: got %0d, want %0d", obs32.size(), exp32.size());
      end
      foreach (exp32[i]) begin
         if (i < obs32.size()) begin
            checks++;
            if (obs32[i] !== exp32[i]) begin
               errors++;
               $display("FAIL rand32_%0d: got r=%0d s=%b cyc=%0d, want r=%0d s=%b cyc=%0d",
                        i, obs32[i].r, obs32[i].s, obs32[i].c, exp32[i].r, exp32[i].s, exp32[i].c);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      start();
      beat(1, 1, 0, 16'sh7FFF, 16'sh7FFF);
      for (int i = 0; i < 8; i++) beat(1, 1, 1, 16'sh4000, 16'sh4000);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL rst_stream_active: got out_valid=%b, want 1", out_valid);
      end
      #2;
      reset = 1'b1;
      in_valid = 1'b0; first = 1'b0; last = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 16'sh0000 || sat !== 1'b0 || out_valid32 !== 1'b0) begin
         errors++;
         $display("FAIL rst_immediate: got v=%b r=%h s=%b v32=%b, want all 0", out_valid, result, sat, out_valid32);
      end
      m_acc = 0; m_fs = 0; m_acc32 = 0; m_fs32 = 0;
      start();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      idle(10);
      checks++;
      if (obs.size() !== 0 || obs32.size() !== 0) begin
         errors++; $display("FAIL rst_stale: got %0d/%0d pulses after reset, want 0", obs.size(), obs32.size());
      end
      beat(1, 0, 1, 16'sh4000, 16'sh4000);
      idle(6);
      checks++;
      if (obs.size() !== 1 || (obs.size() == 1 && (obs[0].r !== 16'sh2000 || obs[0] !== exp_q[0]))) begin
         errors++; $display("FAIL rst_recover: got %0d pulses, want 1 with r=2000", obs.size());
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; first = 1'b0; last = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_rounding();
      test_saturation();
      test_bubbles_abandon();
      test_acc32();
      test_back_to_back();
      test_random_frames();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
